// File: rtl/light_hash_des.sv
// light_hash_des: 32-bit streaming hash built on the DES S1 substitution box.
// One message byte is absorbed per clock while M_valid is high. The latched
// message length decides when the digest is published on hash_ready/digest.
// Optional build macro LHD_LENGTH_FINAL_EN: once the message bytes are in,
// the 8 bytes of the latched length (LSB first) are absorbed as a trailer.
module light_hash_des (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [7:0]  M,
  input  logic [63:0] input_lenght,
  output logic        hash_ready,
  output logic [31:0] digest
);

  // Packed IV, nibble i is H[i]: 4,B,7,1,D,F,0,3.
  localparam logic [31:0] Iv = 32'h30FD17B4;

  // DES S1 rows, column 0 in the least significant nibble.
  localparam logic [63:0] S1Row0 = 64'h7095_C6A3_8BF2_1D4E;
  localparam logic [63:0] S1Row1 = 64'h8359_BC6A_1D2E_47F0;
  localparam logic [63:0] S1Row2 = 64'h05A3_79CF_B26D_8E14;
  localparam logic [63:0] S1Row3 = 64'hD60A_E3B5_7194_28CF;

  // Rotation amount per word, 2 bits each, word 0 in bits [1:0]: 0,1,1,2,2,3,3,0.
  localparam logic [15:0] KTab = 16'h3E94;

`ifdef LHD_LENGTH_FINAL_EN
  typedef enum logic [1:0] {StIdle, StAbsorb, StDone, StFinal} state_t;
`else
  typedef enum logic [1:0] {StIdle, StAbsorb, StDone} state_t;
`endif

  // Byte to S-box input bit shuffle.
  function automatic logic [5:0] pre6(input logic [7:0] b);
    return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
  endfunction

  // Substitute a byte through DES S1 after preprocessing.
  function automatic logic [3:0] sbox(input logic [7:0] b);
    logic [5:0]  m6;
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] tab;
    m6  = pre6(b);
    row = {m6[5], m6[0]};
    col = m6[4:1];
    case (row)
      2'd0:    tab = S1Row0;
      2'd1:    tab = S1Row1;
      2'd2:    tab = S1Row2;
      default: tab = S1Row3;
    endcase
    return tab[{col, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] k);
    logic [7:0] d;
    d = {x, x} << k;
    return d[7:4];
  endfunction

  // Four parallel-update rounds; every word reads its neighbour from the prior round.
  function automatic logic [31:0] compress(input logic [31:0] h_in, input logic [3:0] s);
    logic [31:0] cur;
    logic [31:0] nxt;
    cur = h_in;
    nxt = '0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        nxt[4*i +: 4] = rotl4(cur[4*((i + 1) % 8) +: 4] ^ s, KTab[2*i +: 2]);
      end
      cur = nxt;
    end
    return cur;
  endfunction

  state_t      state_q;
  logic [31:0] h_q;
  logic [63:0] cnt_q;
  logic [63:0] len_q;

  logic [3:0]  s_msg;
  logic [31:0] h_from_iv;
  logic [31:0] h_next;
  logic [63:0] cnt_inc;

  assign s_msg     = sbox(M);
  assign h_from_iv = compress(Iv, s_msg);
  assign h_next    = compress(h_q, s_msg);
  assign cnt_inc   = cnt_q + 64'd1;

`ifdef LHD_LENGTH_FINAL_EN
  logic [2:0]  fin_idx_q;
  logic [31:0] h_fin;

  assign h_fin = compress(h_q, sbox(len_q[{fin_idx_q, 3'b000} +: 8]));
`endif

  // Message FSM, chaining state and registered digest outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      h_q        <= Iv;
      cnt_q      <= '0;
      len_q      <= '0;
      hash_ready <= 1'b0;
      digest     <= '0;
`ifdef LHD_LENGTH_FINAL_EN
      fin_idx_q  <= '0;
`endif
    end else begin
      case (state_q)
        // A byte in IDLE or DONE always opens a fresh message from the IV.
        StIdle, StDone: begin
          if (M_valid) begin
            len_q <= input_lenght;
            cnt_q <= 64'd1;
            h_q   <= h_from_iv;
            if (input_lenght <= 64'd1) begin
`ifdef LHD_LENGTH_FINAL_EN
              state_q    <= StFinal;
              fin_idx_q  <= '0;
              hash_ready <= 1'b0;
`else
              state_q    <= StDone;
              digest     <= h_from_iv;
              hash_ready <= 1'b1;
`endif
            end else begin
              state_q    <= StAbsorb;
              hash_ready <= 1'b0;
            end
          end
        end
        StAbsorb: begin
          if (M_valid) begin
            h_q   <= h_next;
            cnt_q <= cnt_inc;
            if (cnt_inc >= len_q) begin
`ifdef LHD_LENGTH_FINAL_EN
              state_q   <= StFinal;
              fin_idx_q <= '0;
`else
              state_q    <= StDone;
              digest     <= h_next;
              hash_ready <= 1'b1;
`endif
            end
          end
        end
`ifdef LHD_LENGTH_FINAL_EN
        // Length trailer: one byte per cycle, M_valid ignored.
        StFinal: begin
          h_q       <= h_fin;
          fin_idx_q <= fin_idx_q + 3'd1;
          if (fin_idx_q == 3'd7) begin
            state_q    <= StDone;
            digest     <= h_fin;
            hash_ready <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_light_hash_des.sv
// Scoreboard bench for light_hash_des: stimulus pushes expected digest and
// ready cycle from a table-driven reference model; a monitor pops on each
// rising hash_ready and compares.
module tb_light_hash_des;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [7:0]  M;
  logic [63:0] input_lenght;
  logic        hash_ready;
  logic [31:0] digest;

  always #5 clk = ~clk;

  light_hash_des dut (
    .clk          (clk),
    .reset        (reset),
    .M_valid      (M_valid),
    .M            (M),
    .input_lenght (input_lenght),
    .hash_ready   (hash_ready),
    .digest       (digest)
  );

`ifdef LHD_LENGTH_FINAL_EN
  localparam int Extra = 8;
`else
  localparam int Extra = 0;
`endif

  // DES S1 in the textbook row-major layout.
  int s1_tab [0:63] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13};
  int kk [0:7] = '{0, 1, 1, 2, 2, 3, 3, 0};
  int mh [0:7];

  typedef struct {
    logic [31:0] dig;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] msg_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sbox_ref(input int b);
    int m6;
    m6 = ((((b >> 7) ^ (b >> 1)) & 1) << 5) | (((b >> 3) & 1) << 4) | (((b >> 2) & 1) << 3)
       | ((((b >> 5) ^ b) & 1) << 2) | (((b >> 4) & 1) << 1) | ((b >> 6) & 1);
    return s1_tab[(((m6 >> 5) & 1) * 2 + (m6 & 1)) * 16 + ((m6 >> 1) & 15)];
  endfunction

  function automatic void model_absorb(input int b);
    int s;
    int t [0:7];
    s = sbox_ref(b);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        int v;
        v = (mh[(i + 1) % 8] ^ s) & 15;
        t[i] = ((v << kk[i]) | (v >> (4 - kk[i]))) & 15;
      end
      mh = t;
    end
  endfunction

  function automatic logic [31:0] model_hash(input logic [63:0] len);
    logic [31:0] d;
    mh = '{4, 11, 7, 1, 13, 15, 0, 3};
    foreach (msg_q[j]) model_absorb(int'(msg_q[j]));
`ifdef LHD_LENGTH_FINAL_EN
    for (int j = 0; j < 8; j++) model_absorb(int'((len >> (8 * j)) & 64'hFF));
`endif
    d = '0;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = mh[i][3:0];
    return d;
  endfunction

  // pat: 0 = i mod 256, 1 = random, 2 = "abcd..."
  task automatic run_msg(input logic [63:0] len, input int pat, input bit stalls);
    int nb;
    int t;
    logic [31:0] dig;
    exp_t e;
    nb = (len == 0) ? 1 : int'(len);
    msg_q.delete();
    for (int i = 0; i < nb; i++) begin
      if (pat == 0) msg_q.push_back(8'(i % 256));
      else if (pat == 1) msg_q.push_back(8'($urandom_range(0, 255)));
      else msg_q.push_back(8'(8'h61 + i));
    end
    dig = model_hash(len);
    for (int i = 0; i < nb; i++) begin
      if (stalls && i > 0 && $urandom_range(0, 7) == 0) begin
        M_valid = 1'b0;
        input_lenght = {$urandom, $urandom};
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      M_valid = 1'b1;
      M = msg_q[i];
      input_lenght = (i == 0) ? len : {$urandom, $urandom};
      if (i == nb - 1) begin
        e.dig = dig;
        e.cyc = cyc + 1 + Extra;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (i == 0) check("ready_after_first_byte", 64'(hash_ready), 64'(nb == 1 && Extra == 0));
    end
    M_valid = 1'b0;
    t = 0;
    while (!hash_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!hash_ready) check("ready_timeout", 64'(hash_ready), 64'd1);
  endtask

  // Monitor: every rising hash_ready must match the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hash_ready && !prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("digest", 64'(digest), 64'(e.dig));
          check("ready_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev = hash_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    M_valid = 1'b0;
    M = '0;
    input_lenght = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(hash_ready), 64'd0);
    check("reset_digest", 64'(digest), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single zero byte.
    run_msg(64'd1, 0, 1'b0);

    // Long message, back-to-back, then hold check.
    run_msg(64'd3000, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("ready_held", 64'(hash_ready), 64'd1);

    // Same message with stalls.
    run_msg(64'd3000, 0, 1'b1);

    // "abcd" twice straight from DONE.
    run_msg(64'd4, 2, 1'b0);
    run_msg(64'd4, 2, 1'b0);

    // Random short messages.
    for (int k = 0; k < 6; k++) run_msg(64'($urandom_range(2, 40)), 1, 1'b1);

    // Reset mid-message discards progress.
    for (int i = 0; i < 5; i++) begin
      M_valid = 1'b1;
      M = 8'($urandom_range(0, 255));
      input_lenght = 64'd10;
      @(negedge clk);
    end
    M_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_ready", 64'(hash_ready), 64'd0);
    check("midreset_digest", 64'(digest), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero length behaves as a 1-byte message.
    run_msg(64'd0, 1, 1'b0);
    run_msg(64'd5, 1, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/light_hash_des.md
Name: light_hash_des

Overview:
- Lightweight 32-bit hash engine built on the DES S1 substitution box.
- Absorbs a byte stream, one byte per clock under a valid strobe.
- Message length in bytes is supplied on a side port; it sets when the hash is complete.
- Sits as a streaming hash accelerator between a byte source and a consumer that samples the digest on a ready flag.

Parameters:
- None. All widths are fixed: byte input 8, length 64, digest 32.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- M_valid  input  1  M holds a message byte this cycle.
- M  input  8  message byte.
- input_lenght  input  64  message length in bytes; sampled on the first byte of a message.
- hash_ready  output  1  digest valid; held until the next message starts.
- digest  output  32  hash result; digest[4i+3:4i] = H[i].

Behaviour:
- State: eight 4-bit words H[0..7], 64-bit byte counter, 64-bit latched length, FSM {IDLE, ABSORB, DONE}.
- IV: H0..H7 = 4,B,7,1,D,F,0,3, so the packed IV is 0x30FD17B4.
- Reset (async, active-high):
  - H=IV, counter=0, length=0, state=IDLE.
  - hash_ready=0, digest=0.
  - Reset mid-message discards all progress.
- Byte preprocessing: M6 = {M[7]^M[1], M[3], M[2], M[5]^M[0], M[4], M[6]} (bit5..bit0).
- S-box: standard DES S1 (FIPS 46-3).
  - row = {M6[5], M6[0]}, col = M6[4:1].
  - Row 0 = 14 4 13 1 2 15 11 8 3 10 6 12 5 9 0 7.
  - s = S1(M6), constant across all rounds for one byte.
- Compression, per byte, fully combinational in one cycle:
  - 4 rounds; each round updates all 8 words in parallel from the previous round's values.
  - H'[i] = rotl4(H[(i+1) mod 8] ^ s, k_i).
  - k = 0,1,1,2,2,3,3,0 for i = 0..7.
- IDLE, M_valid=1:
  - Latch input_lenght.
  - Absorb M starting from IV; counter=1; go to ABSORB.
  - If latched length ≤ 1, go directly to DONE instead.
- ABSORB:
  - M_valid=1: absorb byte, counter+1. When the counter reaches the length, go to DONE.
  - M_valid=0: stall, no state change.
  - input_lenght changes during a message are ignored.
- Entering DONE: digest <= compressed H at that same edge; hash_ready=1.
  - Latency: hash_ready high on the edge after the edge that captures the last byte.
- DONE:
  - digest and hash_ready held.
  - M_valid=1 starts a new message as in IDLE: hash_ready drops to 0 at that edge and H restarts from IV.
- Zero length: M_valid=1 with input_lenght=0 goes to DONE, and the byte is absorbed as a 1-byte message.
- No backpressure; the source is never stalled.

Optional Feature:
- Macro LHD_LENGTH_FINAL_EN.
- Defined:
  - After the last message byte, the FSM enters a FINAL state.
  - It absorbs the 8 bytes of the latched length, LSB byte first, one per cycle, with the same compression.
  - M_valid is ignored in FINAL.
  - hash_ready rises 8 cycles later than the base timing.
- Undefined:
  - FINAL state and its logic are absent.
  - Digest covers message bytes only, with timing as in Behaviour.

Test Plan:
- Reset: hold reset=1 → hash_ready=0, digest=0x00000000. Assert reset mid-message → all state cleared, next message hashes from IV.
- Single byte 0x00, length 1 → s=0xE; hash_ready=1 one cycle after the byte; digest matches the golden model seeded with IV 0x30FD17B4.
- Long string: length 3000, bytes M=i mod 256 streamed back-to-back → hash_ready high 1 cycle after byte 2999 and still high 3 cycles after; digest equals the model.
- Stalls: same 3000-byte message with M_valid dropped randomly for 1–5 cycles → identical digest; hash_ready never rises before byte 3000.
- Back-to-back messages: length 4 "abcd", then length 4 "abcd" again immediately from DONE → hash_ready drops on the first new byte; both digests identical, proving the IV restart.
- LHD_LENGTH_FINAL_EN defined: length 1, byte 0x00 → hash_ready 9 cycles after the byte; digest differs from the undefined build and matches the model with the length appended.
